calc_entry: RTL

Keypad-to-arithmetic front end of the calculator. Consumes the `code`/`press` events produced by the keypad stage. Digit keys build decimal operands, operator keys latch the pending operation, and EQU evaluates it. The current entry or result is presented as a signed value to the display stage downstream.

---
 rtl/calc_entry.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_entry.sv
// calc_entry: keypad-driven signed calculator front end (entry FSM, ALU, optional divider).
// Define CALC_DIV_EN to build the iterative restoring divider and its CALC state.
module calc_entry #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              code,
    input  logic                    press,
    output logic signed [WIDTH-1:0] display,
    output logic                    result_valid,
    output logic                    busy,
    output logic                    err
);
    typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, CALC, RESULT, ERROR} state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [3:0] K_EQU  = 4'd14;
    localparam logic [3:0] K_CLR  = 4'd15;
    localparam logic signed [2*WIDTH-1:0] MAX_X = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

    state_t                  state, state_n;
    logic signed [WIDTH-1:0] a, a_n, b, b_n, display_n;
    logic [1:0]              op, op_n, new_op;
    logic                    result_valid_n, busy_n, err_n;
    logic [2:0]              sync_q;
    logic                    evt, is_digit, is_op;
    logic                    do_eval, chained, go_err;

    logic signed [2*WIDTH-1:0] acc_ext, acc_new, prod;
    logic        [WIDTH:0]     sum_x, diff_x;
    logic signed [WIDTH-1:0]   alu_res;
    logic                      alu_err, digit_ovf;

    // sync_q[2] is the delayed copy used for rising-edge detection
    assign evt      = sync_q[1] & ~sync_q[2];
    assign is_digit = (code <= 4'd9);
    assign new_op   = 2'(code - 4'd10);
`ifdef CALC_DIV_EN
    localparam logic [1:0]        OP_DIV = 2'd3;
    localparam int                CNT_W  = $clog2(WIDTH + 1);
    localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] dvd, dvd_n, dvs, dvs_n, rem, rem_n, quot;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             neg, neg_n, chain_q, chain_n;
    logic [1:0]       pend, pend_n;
    logic [WIDTH:0]   rem_sh, trial;

    assign is_op  = (code >= 4'd10) && (code <= 4'd13);
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, dvs};
    assign quot   = neg ? (~dvd + 1'b1) : dvd;
`else
    assign is_op  = (code >= 4'd10) && (code <= 4'd12);
`endif

    always_comb begin
        acc_ext = '0;
        alu_res = '0;
        alu_err = 1'b0;
        if (state == ENTER_A)      acc_ext = {{WIDTH{a[WIDTH-1]}}, a};
        else if (state == ENTER_B) acc_ext = {{WIDTH{b[WIDTH-1]}}, b};
        acc_new = (acc_ext <<< 3) + (acc_ext <<< 1) + {{(2*WIDTH-4){1'b0}}, code};
        sum_x   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        diff_x  = {a[WIDTH-1], a} - {b[WIDTH-1], b};
        prod    = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        case (op)
            OP_SUB: begin
                alu_res = diff_x[WIDTH-1:0];
                alu_err = diff_x[WIDTH] ^ diff_x[WIDTH-1];
            end
            OP_MUL: begin
                alu_res = prod[WIDTH-1:0];
                // product fits only if the top WIDTH+1 bits are a pure sign extension
                alu_err = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
            end
            default: begin
                alu_res = sum_x[WIDTH-1:0];
                alu_err = sum_x[WIDTH] ^ sum_x[WIDTH-1];
            end
        endcase
    end

    assign digit_ovf = (acc_new > MAX_X);

    always_comb begin
        state_n        = state;
        a_n            = a;
        b_n            = b;
        op_n           = op;
        display_n      = display;
        result_valid_n = 1'b0;
        busy_n         = busy;
        err_n          = err;
        do_eval        = 1'b0;
        chained        = 1'b0;
        go_err         = 1'b0;
`ifdef CALC_DIV_EN
        dvd_n   = dvd;
        dvs_n   = dvs;
        rem_n   = rem;
        cnt_n   = cnt;
        neg_n   = neg;
        chain_n = chain_q;
        pend_n  = pend;
`endif
        if (evt && code == K_CLR) begin
            state_n   = ENTER_A;
            a_n       = '0;
            b_n       = '0;
            op_n      = OP_ADD;
            display_n = '0;
            busy_n    = 1'b0;
            err_n     = 1'b0;
        end else begin
            case (state)
                ENTER_A, OP_WAIT, ENTER_B, RESULT: if (evt) begin
                    if (is_digit) begin
                        if (digit_ovf) go_err = 1'b1;
                        else begin
                            display_n = acc_new[WIDTH-1:0];
                            if (state == ENTER_A || state == RESULT) begin
                                a_n     = acc_new[WIDTH-1:0];
                                state_n = ENTER_A;
                            end else begin
                                b_n     = acc_new[WIDTH-1:0];
                                state_n = ENTER_B;
                            end
                        end
                    end else if (is_op) begin
                        if (state == ENTER_B) begin
                            do_eval = 1'b1;
                            chained = 1'b1;
                        end else begin
                            op_n    = new_op;
                            state_n = OP_WAIT;
                        end
                    end else if (code == K_EQU) begin
                        if (state == ENTER_B) do_eval = 1'b1;
                        else if (state == ENTER_A) begin
                            display_n      = a;
                            result_valid_n = 1'b1;
                            state_n        = RESULT;
                        end
                    end
                end
`ifdef CALC_DIV_EN
                CALC: begin
                    if (cnt == CNT_W'(WIDTH)) begin
                        display_n      = quot;
                        a_n            = quot;
                        result_valid_n = 1'b1;
                        busy_n         = 1'b0;
                        state_n        = chain_q ? OP_WAIT : RESULT;
                        if (chain_q) op_n = pend;
                    end else begin
                        rem_n = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                        dvd_n = {dvd[WIDTH-2:0], ~trial[WIDTH]};
                        cnt_n = cnt + 1'b1;
                    end
                end
`endif
                default: ;
            endcase

            if (do_eval) begin
`ifdef CALC_DIV_EN
                if (op == OP_DIV) begin
                    // zero divisor and MIN/-1 are rejected before the divider starts
                    if (b == '0 || (a == MIN_V && b == '1)) go_err = 1'b1;
                    else begin
                        dvd_n   = a[WIDTH-1] ? (~a + 1'b1) : a;
                        dvs_n   = b[WIDTH-1] ? (~b + 1'b1) : b;
                        rem_n   = '0;
                        cnt_n   = '0;
                        neg_n   = a[WIDTH-1] ^ b[WIDTH-1];
                        chain_n = chained;
                        pend_n  = new_op;
                        busy_n  = 1'b1;
                        state_n = CALC;
                    end
                end else
`endif
                if (alu_err) go_err = 1'b1;
                else begin
                    display_n      = alu_res;
                    a_n            = alu_res;
                    result_valid_n = 1'b1;
                    state_n        = chained ? OP_WAIT : RESULT;
                    if (chained) op_n = new_op;
                end
            end

            if (go_err) begin
                err_n     = 1'b1;
                display_n = '0;
                busy_n    = 1'b0;
                state_n   = ERROR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            state        <= ENTER_A;
            a            <= '0;
            b            <= '0;
            op           <= OP_ADD;
            display      <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            sync_q       <= {sync_q[1:0], press};
            state        <= state_n;
            a            <= a_n;
            b            <= b_n;
            op           <= op_n;
            display      <= display_n;
            result_valid <= result_valid_n;
            busy         <= busy_n;
            err          <= err_n;
        end
    end

`ifdef CALC_DIV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            chain_q <= 1'b0;
            pend    <= OP_ADD;
        end else begin
            dvd     <= dvd_n;
            dvs     <= dvs_n;
            rem     <= rem_n;
            cnt     <= cnt_n;
            neg     <= neg_n;
            chain_q <= chain_n;
            pend    <= pend_n;
        end
    end
`endif
endmodule
